// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / result-out handshake bundle for the ALU issue controller.
interface alu_issue_ctrl_if;
  localparam int unsigned DW = 32;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] instr;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] resultado;
  logic          zero;
  logic          branch_taken;
  logic          illegal;

  // Producer of instructions and consumer of results.
  modport master (
    output in_valid, instr, rs_val, rt_val, out_ready,
    input  in_ready, out_valid, resultado, zero, branch_taken, illegal
  );

  // The issue controller itself.
  modport slave (
    input  in_valid, instr, rs_val, rt_val, out_ready,
    output in_ready, out_valid, resultado, zero, branch_taken, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Decodes one MIPS-style instruction, drives the external combinational ALU
// from registers, and returns the captured result over a valid/ready handshake.
module alu_issue_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_ctrl_if.slave     bus,
  output logic [31:0]         alu_dato1,
  output logic [31:0]         alu_dato2,
  output logic [3:0]          alu_op,
  input  logic [31:0]         alu_datoout,
  input  logic                alu_zf,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_AND = 4'b0000;
  localparam logic [OPW-1:0] OP_OR  = 4'b0001;
  localparam logic [OPW-1:0] OP_ADD = 4'b0010;
  localparam logic [OPW-1:0] OP_SUB = 4'b0110;
  localparam logic [OPW-1:0] OP_SLT = 4'b0111;
  localparam logic [OPW-1:0] OP_NOR = 4'b1100;
  localparam logic [OPW-1:0] OP_ILL = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state_q, state_d;

  logic [5:0]     opcode, funct;
  logic [15:0]    imm;
  logic [OPW-1:0] dec_op;
  logic [DW-1:0]  dec_d2;
  logic           dec_beq, dec_ill;
  logic           is_beq_q, illegal_q;

  logic accept_c, retire_c, load_res_c, in_ready_d, out_valid_d;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];
  assign imm    = bus.instr[15:0];

  // Instruction decode: ALU op code, second operand and status flags.
  always_comb begin
    dec_op  = OP_ILL;
    dec_d2  = bus.rt_val;
    dec_beq = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   dec_op = OP_ADD;
          6'h22:   dec_op = OP_SUB;
          6'h24:   dec_op = OP_AND;
          6'h25:   dec_op = OP_OR;
          6'h27:   dec_op = OP_NOR;
          6'h2A:   dec_op = OP_SLT;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h23, 6'h2B: begin
        dec_op = OP_ADD;
        dec_d2 = {{16{imm[15]}}, imm};
      end
      6'h0A: begin
        dec_op = OP_SLT;
        dec_d2 = {{16{imm[15]}}, imm};
      end
      6'h0C: begin
        dec_op = OP_AND;
        dec_d2 = {16'h0000, imm};
      end
      6'h0D: begin
        dec_op = OP_OR;
        dec_d2 = {16'h0000, imm};
      end
      6'h04: begin
        dec_op  = OP_SUB;
        dec_beq = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, one EXEC cycle, hold in DONE until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid && bus.in_ready) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (bus.out_valid && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/enable logic; handshake flags are pre-computed and registered below.
  always_comb begin
    accept_c    = 1'b0;
    load_res_c  = 1'b0;
    retire_c    = 1'b0;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE:    accept_c   = bus.in_valid && bus.in_ready;
      EXEC:    load_res_c = 1'b1;
      DONE:    retire_c   = bus.out_valid && bus.out_ready;
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready     <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.resultado    <= '0;
      bus.zero         <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.illegal      <= 1'b0;
      alu_dato1        <= '0;
      alu_dato2        <= '0;
      alu_op           <= '0;
      is_beq_q         <= 1'b0;
      illegal_q        <= 1'b0;
      retired          <= '0;
    end else begin
      bus.in_ready  <= in_ready_d;
      bus.out_valid <= out_valid_d;
      if (accept_c) begin
        alu_dato1 <= bus.rs_val;
        alu_dato2 <= dec_d2;
        alu_op    <= dec_op;
        is_beq_q  <= dec_beq;
        illegal_q <= dec_ill;
      end
      if (load_res_c) begin
        bus.resultado    <= alu_datoout;
        bus.zero         <= alu_zf;
        bus.branch_taken <= is_beq_q & alu_zf;
        bus.illegal      <= illegal_q;
      end
      if (retire_c) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the operand side.
module tb_alu_issue_ctrl;

  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       alu_dato1, alu_dato2, alu_datoout;
  logic [3:0]        alu_op;
  logic              alu_zf;
  logic [CNT_W-1:0]  retired;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_dato1   (alu_dato1),
    .alu_dato2   (alu_dato2),
    .alu_op      (alu_op),
    .alu_datoout (alu_datoout),
    .alu_zf      (alu_zf),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: unsigned slt, unknown op codes return 0.
  always_comb begin
    case (alu_op)
      4'b0000: alu_datoout = alu_dato1 & alu_dato2;
      4'b0001: alu_datoout = alu_dato1 | alu_dato2;
      4'b0010: alu_datoout = alu_dato1 + alu_dato2;
      4'b0110: alu_datoout = alu_dato1 - alu_dato2;
      4'b0111: alu_datoout = (alu_dato1 < alu_dato2) ? 32'd1 : 32'd0;
      4'b1100: alu_datoout = ~(alu_dato1 | alu_dato2);
      default: alu_datoout = 32'd0;
    endcase
    alu_zf = (alu_datoout == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  // Issue one instruction, check EXEC-phase ALU drive, result, and completion.
  task automatic run(input string name, input logic [31:0] ins, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [3:0] eop, input logic ck2,
                     input logic [31:0] ed2, input logic [31:0] eres, input logic ez,
                     input logic ebr, input logic eill);
    wait_ready();
    bus.instr    = ins;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.instr    = 32'hFFFF_FFFF;
    bus.rs_val   = 32'h5A5A_5A5A;
    bus.rt_val   = 32'hA5A5_A5A5;
    chk({name, ".alu_op"}, 32'(alu_op), 32'(eop));
    chk({name, ".alu_dato1"}, alu_dato1, rs);
    if (ck2) chk({name, ".alu_dato2"}, alu_dato2, ed2);
    chk({name, ".exec_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, ".exec_in_ready"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".resultado"}, bus.resultado, eres);
    chk({name, ".zero"}, 32'(bus.zero), 32'(ez));
    chk({name, ".branch_taken"}, 32'(bus.branch_taken), 32'(ebr));
    chk({name, ".illegal"}, 32'(bus.illegal), 32'(eill));
    @(posedge clk); #1;
    exp_retired++;
    chk({name, ".done_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, ".retired"}, 32'(retired), 32'(exp_retired));
    chk({name, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.instr     = 32'd0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.retired", 32'(retired), 32'd0);
    chk("rst.alu_op", 32'(alu_op), 32'd0);
    chk("rst.resultado", bus.resultado, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.in_ready_rise", 32'(bus.in_ready), 32'd1);

    //   name     instr          rs            rt          op    ck d2            res           z  br ill
    run("add",  32'h0085_1020, 32'd5,        32'd7,      4'h2, 1, 32'd7,        32'd12,       0, 0, 0);
    run("sub",  32'h0085_1022, 32'h1234,     32'h1234,   4'h6, 1, 32'h1234,     32'd0,        1, 0, 0);
    run("beqt", 32'h1085_0003, 32'd3,        32'd3,      4'h6, 1, 32'd3,        32'd0,        1, 1, 0);
    run("beqn", 32'h1085_0003, 32'd3,        32'd4,      4'h6, 1, 32'd4,        32'hFFFF_FFFF,0, 0, 0);
    run("addi", 32'h2085_FFFF, 32'd10,       32'd99,     4'h2, 1, 32'hFFFF_FFFF,32'd9,        0, 0, 0);
    run("ori",  32'h3485_8000, 32'd0,        32'd99,     4'h1, 1, 32'h0000_8000,32'h0000_8000,0, 0, 0);
    run("andi", 32'h3085_8000, 32'hFFFF_FFFF,32'd99,     4'h0, 1, 32'h0000_8000,32'h0000_8000,0, 0, 0);
    run("lw",   32'h8C85_FFFC, 32'h100,      32'd99,     4'h2, 1, 32'hFFFF_FFFC,32'h0000_00FC,0, 0, 0);
    run("nor",  32'h0085_1027, 32'd0,        32'd0,      4'hC, 1, 32'd0,        32'hFFFF_FFFF,0, 0, 0);
    run("slt",  32'h0085_102A, 32'd3,        32'd5,      4'h7, 1, 32'd5,        32'd1,        0, 0, 0);
    run("ill3f",32'hFC00_0000, 32'd5,        32'd7,      4'hF, 0, 32'd0,        32'd0,        1, 0, 1);
    run("illfn",32'h0085_1003, 32'd5,        32'd7,      4'hF, 0, 32'd0,        32'd0,        1, 0, 1);

    // Backpressure: result must hold and no new instruction may be taken.
    bus.out_ready = 1'b0;
    wait_ready();
    bus.instr = 32'h0085_1020; bus.rs_val = 32'd1; bus.rt_val = 32'd2;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr = 32'h0085_1022; bus.rs_val = 32'd100; bus.rt_val = 32'd1;
    @(posedge clk); #1;
    chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp.resultado", bus.resultado, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.hold_res", bus.resultado, 32'd3);
      chk("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp.hold_alu_op", 32'(alu_op), 32'h2);
      chk("bp.hold_retired", 32'(retired), 32'(exp_retired));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    exp_retired++;
    chk("bp.release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp.release_retired", 32'(retired), 32'(exp_retired));
    chk("bp.release_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset while the instruction is in EXEC.
    bus.instr = 32'h0085_1022; bus.rs_val = 32'd9; bus.rt_val = 32'd4;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rmid.exec_alu_op", 32'(alu_op), 32'h6);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_retired = 0;
    chk("rmid.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rmid.retired", 32'(retired), 32'd0);
    chk("rmid.resultado", bus.resultado, 32'd0);
    chk("rmid.alu_dato1", alu_dato1, 32'd0);
    chk("rmid.alu_op", 32'(alu_op), 32'd0);
    chk("rmid.in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rmid.out_valid_after", 32'(bus.out_valid), 32'd0);
    run("add2", 32'h0085_1020, 32'd2, 32'd2, 4'h2, 1, 32'd2, 32'd4, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
